// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg
//   Shared definitions for the two-requester SRAM arbiter. It holds the
//   arbiter state encoding and the requester index constants.
//   Ports: none (package).
package sram_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,   // no response outstanding
        RESP = 1'b1    // one response outstanding; owner/type valid
    } state_t;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// rr_arb2
//   Two-way round-robin selector. A lone request wins outright. When both
//   requests are present, the requester that did not win last time is chosen.
//   Ports:
//     valid[1:0]  in   request lines (bit N = requester N)
//     last_grant  in   index of the most recently accepted requester
//     grant[1:0]  out  one-hot grant, all zero when nothing is requesting
module rr_arb2
    import sram_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: every path assigns grant, and the default comes first, so no latch is inferred.
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == REQ_M0) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one external single-port SRAM between two requesters. At most one
//   response is outstanding. A new request can issue in the same cycle that
//   the outstanding response is taken, so back-to-back traffic reaches one
//   request per clock.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     mN_req_valid/ready         request handshake, requester N (N=0,1)
//     mN_req_we/addr/wdata/mask  request payload
//     mN_rsp_valid/ready         response handshake
//     mN_rsp_rdata               read data (0 for writes and for non-owners)
//     sram_cs/we/addr/data_in/mask  SRAM command, driven only in accept cycles
//     sram_data_out              registered SRAM read data (1-cycle latency)
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  m0_req_valid,
    output logic                  m0_req_ready,
    input  logic                  m0_req_we,
    input  logic [ADDR_WIDTH-1:0] m0_req_addr,
    input  logic [DATA_WIDTH-1:0] m0_req_wdata,
    input  logic [MASK_WIDTH-1:0] m0_req_mask,
    output logic                  m0_rsp_valid,
    input  logic                  m0_rsp_ready,
    output logic [DATA_WIDTH-1:0] m0_rsp_rdata,

    input  logic                  m1_req_valid,
    output logic                  m1_req_ready,
    input  logic                  m1_req_we,
    input  logic [ADDR_WIDTH-1:0] m1_req_addr,
    input  logic [DATA_WIDTH-1:0] m1_req_wdata,
    input  logic [MASK_WIDTH-1:0] m1_req_mask,
    output logic                  m1_rsp_valid,
    input  logic                  m1_rsp_ready,
    output logic [DATA_WIDTH-1:0] m1_rsp_rdata,

    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_data_in,
    output logic [MASK_WIDTH-1:0] sram_mask,
    input  logic [DATA_WIDTH-1:0] sram_data_out
);

    state_t state, state_nxt;
    logic   owner, owner_nxt;            // requester that owns the outstanding response
    logic   rtype, rtype_nxt;            // 1 = outstanding response is for a write
    logic   last_grant, last_grant_nxt;

    logic [1:0] grant;
    logic       owner_rsp_ready;
    logic       handshake;
    logic       can_accept;
    logic       accept;
    logic       sel;
    logic       sel_we;

    rr_arb2 u_rr_arb2 (
        .valid      ({m1_req_valid, m0_req_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= REQ_M0;
            rtype      <= 1'b0;
            last_grant <= REQ_M1;   // so m0 wins the first conflict
        end else begin
            // NOTE: state registers use non-blocking assignments so that every register samples pre-edge values.
            state      <= state_nxt;
            owner      <= owner_nxt;
            rtype      <= rtype_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        rtype_nxt      = rtype;
        last_grant_nxt = last_grant;

        // rsp_valid of the owner is always 1 in RESP, so its rsp_ready alone
        // completes the handshake.
        owner_rsp_ready = (owner == REQ_M1) ? m1_rsp_ready : m0_rsp_ready;
        handshake       = (state == RESP) && owner_rsp_ready;

        // rst_n gates acceptance so that no ready or SRAM select leaks out
        // while reset is held, even though the state already reads IDLE.
        can_accept = rst_n && ((state == IDLE) || handshake);

        m0_req_ready = grant[0] && can_accept;
        m1_req_ready = grant[1] && can_accept;
        accept       = m0_req_ready || m1_req_ready;

        sel    = grant[1] ? REQ_M1 : REQ_M0;
        sel_we = (sel == REQ_M1) ? m1_req_we : m0_req_we;

        sram_cs      = accept;
        sram_we      = accept && sel_we;
        sram_addr    = (sel == REQ_M1) ? m1_req_addr  : m0_req_addr;
        sram_data_in = (sel == REQ_M1) ? m1_req_wdata : m0_req_wdata;
        sram_mask    = '0;
        if (accept && sel_we) begin
            sram_mask = (sel == REQ_M1) ? m1_req_mask : m0_req_mask;
        end

        m0_rsp_valid = (state == RESP) && (owner == REQ_M0);
        m1_rsp_valid = (state == RESP) && (owner == REQ_M1);
        m0_rsp_rdata = (m0_rsp_valid && !rtype) ? sram_data_out : '0;
        m1_rsp_rdata = (m1_rsp_valid && !rtype) ? sram_data_out : '0;

        if (accept) begin
            state_nxt      = RESP;
            owner_nxt      = sel;
            rtype_nxt      = sel_we;
            last_grant_nxt = sel;
        end else if (handshake) begin
            state_nxt = IDLE;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Directed, table-driven bench for sram_arbiter with a 1-cycle-latency
//   byte-masked SRAM model. Each table row gives both requesters' inputs for
//   one cycle and the outputs expected in that cycle. Hand-written sequences
//   cover reset held with requests pending and reset asserted mid-response.
module tb_sram_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid, m0_rsp_ready;
    logic [AW-1:0] m0_req_addr;
    logic [DW-1:0] m0_req_wdata, m0_rsp_rdata;
    logic [MW-1:0] m0_req_mask;
    logic          m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid, m1_rsp_ready;
    logic [AW-1:0] m1_req_addr;
    logic [DW-1:0] m1_req_wdata, m1_rsp_rdata;
    logic [MW-1:0] m1_req_mask;
    logic          sram_cs, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_data_in, sram_data_out;
    logic [MW-1:0] sram_mask;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m0_req_valid  (m0_req_valid),
        .m0_req_ready  (m0_req_ready),
        .m0_req_we     (m0_req_we),
        .m0_req_addr   (m0_req_addr),
        .m0_req_wdata  (m0_req_wdata),
        .m0_req_mask   (m0_req_mask),
        .m0_rsp_valid  (m0_rsp_valid),
        .m0_rsp_ready  (m0_rsp_ready),
        .m0_rsp_rdata  (m0_rsp_rdata),
        .m1_req_valid  (m1_req_valid),
        .m1_req_ready  (m1_req_ready),
        .m1_req_we     (m1_req_we),
        .m1_req_addr   (m1_req_addr),
        .m1_req_wdata  (m1_req_wdata),
        .m1_req_mask   (m1_req_mask),
        .m1_rsp_valid  (m1_rsp_valid),
        .m1_rsp_ready  (m1_rsp_ready),
        .m1_rsp_rdata  (m1_rsp_rdata),
        .sram_cs       (sram_cs),
        .sram_we       (sram_we),
        .sram_addr     (sram_addr),
        .sram_data_in  (sram_data_in),
        .sram_mask     (sram_mask),
        .sram_data_out (sram_data_out)
    );

    // SRAM model: registered read data, held until the next read select.
    logic [DW-1:0] mem [1 << AW];
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) begin
                for (int b = 0; b < MW; b++) begin
                    if (sram_mask[b]) mem[sram_addr][8*b +: 8] <= sram_data_in[8*b +: 8];
                end
            end else begin
                sram_data_out <= mem[sram_addr];
            end
        end
    end

    typedef struct packed {
        logic          v;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [MW-1:0] k;
    } req_t;

    typedef struct packed {
        logic          rdy0, rdy1, rv0, rv1;
        logic [DW-1:0] rd0, rd1;
        logic          cs, we;
        logic [AW-1:0] addr;
        logic [MW-1:0] mask;
    } exp_t;

    typedef struct packed {
        req_t m0;
        logic rr0;
        req_t m1;
        logic rr1;
        exp_t e;
    } vec_t;

    localparam int NROWS = 22;
    vec_t tbl [NROWS];
    req_t nr;

    int checks = 0;
    int errors = 0;

    function automatic req_t rq(input logic we, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic [MW-1:0] k);
        return '{1'b1, we, a, d, k};
    endfunction

    function automatic exp_t ex(input logic rdy0, input logic rdy1, input logic rv0,
                                input logic rv1, input logic [DW-1:0] rd0,
                                input logic [DW-1:0] rd1, input logic cs, input logic we,
                                input logic [AW-1:0] addr, input logic [MW-1:0] mask);
        return '{rdy0, rdy1, rv0, rv1, rd0, rd1, cs, we, addr, mask};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input req_t r0, input logic rr0, input req_t r1, input logic rr1);
        m0_req_valid = r0.v; m0_req_we = r0.we; m0_req_addr = r0.a;
        m0_req_wdata = r0.d; m0_req_mask = r0.k; m0_rsp_ready = rr0;
        m1_req_valid = r1.v; m1_req_we = r1.we; m1_req_addr = r1.a;
        m1_req_wdata = r1.d; m1_req_mask = r1.k; m1_rsp_ready = rr1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nr = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem['h20] = 32'h1122_3344;
        sram_data_out = '0;

        // Idle / single write then read
        tbl[0]  = '{nr, 1'b1, nr, 1'b1, ex(0,0,0,0,0,0,0,0,0,0)};
        tbl[1]  = '{nr, 1'b1, nr, 1'b1, ex(0,0,0,0,0,0,0,0,0,0)};
        tbl[2]  = '{rq(1,'h10,'hDEADBEEF,'hF), 1'b1, nr, 1'b1, ex(1,0,0,0,0,0,1,1,'h10,'hF)};
        tbl[3]  = '{rq(0,'h10,0,'hF), 1'b1, nr, 1'b1, ex(1,0,1,0,0,0,1,0,'h10,0)};
        tbl[4]  = '{nr, 1'b1, nr, 1'b1, ex(0,0,1,0,'hDEADBEEF,0,0,0,0,0)};
        // Byte-masked write by m1, then read back
        tbl[5]  = '{nr, 1'b1, rq(1,'h20,'hAABBCCDD,'h2), 1'b1, ex(0,1,0,0,0,0,1,1,'h20,'h2)};
        tbl[6]  = '{nr, 1'b1, rq(0,'h20,0,0), 1'b1, ex(0,1,0,1,0,0,1,0,'h20,0)};
        tbl[7]  = '{nr, 1'b1, nr, 1'b1, ex(0,0,0,1,0,'h1122CC44,0,0,0,0)};
        // Conflict: grants alternate m0,m1,m0,m1
        tbl[8]  = '{rq(0,'h10,0,0), 1'b1, rq(0,'h20,0,0), 1'b1, ex(1,0,0,0,0,0,1,0,'h10,0)};
        tbl[9]  = '{rq(0,'h10,0,0), 1'b1, rq(0,'h20,0,0), 1'b1, ex(0,1,1,0,'hDEADBEEF,0,1,0,'h20,0)};
        tbl[10] = '{rq(0,'h10,0,0), 1'b1, rq(0,'h20,0,0), 1'b1, ex(1,0,0,1,0,'h1122CC44,1,0,'h10,0)};
        tbl[11] = '{rq(0,'h10,0,0), 1'b1, rq(0,'h20,0,0), 1'b1, ex(0,1,1,0,'hDEADBEEF,0,1,0,'h20,0)};
        tbl[12] = '{nr, 1'b1, nr, 1'b1, ex(0,0,0,1,0,'h1122CC44,0,0,0,0)};
        // Backpressure: m0 read response stalled 3 cycles, m1 waiting
        tbl[13] = '{rq(0,'h10,0,0), 1'b1, nr, 1'b1, ex(1,0,0,0,0,0,1,0,'h10,0)};
        tbl[14] = '{nr, 1'b0, rq(1,'h30,'h55,'hF), 1'b1, ex(0,0,1,0,'hDEADBEEF,0,0,0,0,0)};
        tbl[15] = '{nr, 1'b0, rq(1,'h30,'h55,'hF), 1'b1, ex(0,0,1,0,'hDEADBEEF,0,0,0,0,0)};
        tbl[16] = '{nr, 1'b0, rq(1,'h30,'h55,'hF), 1'b1, ex(0,0,1,0,'hDEADBEEF,0,0,0,0,0)};
        tbl[17] = '{nr, 1'b1, rq(1,'h30,'h55,'hF), 1'b1, ex(0,1,1,0,'hDEADBEEF,0,1,1,'h30,'hF)};
        tbl[18] = '{nr, 1'b1, nr, 1'b1, ex(0,0,0,1,0,0,0,0,0,0)};
        // Write with mask 0 is acknowledged and leaves the word unchanged
        tbl[19] = '{rq(1,'h20,'hFFFFFFFF,'h0), 1'b1, nr, 1'b1, ex(1,0,0,0,0,0,1,1,'h20,0)};
        tbl[20] = '{rq(0,'h20,0,0), 1'b1, nr, 1'b1, ex(1,0,1,0,0,0,1,0,'h20,0)};
        tbl[21] = '{nr, 1'b1, nr, 1'b1, ex(0,0,1,0,'h1122CC44,0,0,0,0,0)};

        // Reset held with both requesters valid: nothing may leak out.
        rst_n = 1'b0;
        drive(rq(1,'h10,'h1,'hF), 1'b1, rq(0,'h20,0,0), 1'b1);
        #2;
        check("rst m0_req_ready", 32'(m0_req_ready), 0);
        check("rst m1_req_ready", 32'(m1_req_ready), 0);
        check("rst sram_cs",      32'(sram_cs), 0);
        check("rst sram_we",      32'(sram_we), 0);
        check("rst sram_mask",    32'(sram_mask), 0);
        check("rst rsp_valid",    32'({m1_rsp_valid, m0_rsp_valid}), 0);
        check("rst m0_rsp_rdata", m0_rsp_rdata, 0);
        check("rst m1_rsp_rdata", m1_rsp_rdata, 0);
        @(posedge clk);
        @(negedge clk);
        drive(nr, 1'b1, nr, 1'b1);
        rst_n = 1'b1;

        for (int i = 0; i < NROWS; i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i].m0, tbl[i].rr0, tbl[i].m1, tbl[i].rr1);
            #2;
            check($sformatf("row%0d m0_req_ready", i), 32'(m0_req_ready), 32'(tbl[i].e.rdy0));
            check($sformatf("row%0d m1_req_ready", i), 32'(m1_req_ready), 32'(tbl[i].e.rdy1));
            check($sformatf("row%0d m0_rsp_valid", i), 32'(m0_rsp_valid), 32'(tbl[i].e.rv0));
            check($sformatf("row%0d m1_rsp_valid", i), 32'(m1_rsp_valid), 32'(tbl[i].e.rv1));
            check($sformatf("row%0d m0_rsp_rdata", i), m0_rsp_rdata, tbl[i].e.rd0);
            check($sformatf("row%0d m1_rsp_rdata", i), m1_rsp_rdata, tbl[i].e.rd1);
            check($sformatf("row%0d sram_cs", i),      32'(sram_cs), 32'(tbl[i].e.cs));
            check($sformatf("row%0d sram_we", i),      32'(sram_we), 32'(tbl[i].e.we));
            check($sformatf("row%0d sram_mask", i),    32'(sram_mask), 32'(tbl[i].e.mask));
            if (tbl[i].e.cs) begin
                check($sformatf("row%0d sram_addr", i), 32'(sram_addr), 32'(tbl[i].e.addr));
            end
        end

        // Mid-operation reset: m0 read outstanding and stalled, then reset.
        @(posedge clk);
        #1;
        drive(rq(0,'h10,0,0), 1'b0, nr, 1'b1);
        #2;
        check("mid accept m0_req_ready", 32'(m0_req_ready), 1);
        @(posedge clk);
        #1;
        drive(nr, 1'b0, nr, 1'b1);
        #2;
        check("mid pending m0_rsp_valid", 32'(m0_rsp_valid), 1);
        drive(nr, 1'b0, rq(1,'h40,'h77,'hF), 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid async m0_rsp_valid", 32'(m0_rsp_valid), 0);
        check("mid async m0_rsp_rdata", m0_rsp_rdata, 0);
        check("mid async m1_req_ready", 32'(m1_req_ready), 0);
        check("mid async sram_cs",      32'(sram_cs), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(nr, 1'b1, rq(1,'h40,'h77,'hF), 1'b1);
        #1;
        check("post rst m0_rsp_valid", 32'(m0_rsp_valid), 0);
        check("post rst m1_rsp_valid", 32'(m1_rsp_valid), 0);
        check("post rst m1_req_ready", 32'(m1_req_ready), 1);
        check("post rst sram_cs",      32'(sram_cs), 1);
        @(posedge clk);
        #1;
        drive(nr, 1'b1, nr, 1'b1);
        #2;
        check("post rst m0_rsp_valid 2", 32'(m0_rsp_valid), 0);
        check("post rst m1_rsp_valid 2", 32'(m1_rsp_valid), 1);
        check("post rst m1_rsp_rdata",   m1_rsp_rdata, 0);
        @(posedge clk);
        #3;
        check("post rst m0_rsp_valid 3", 32'(m0_rsp_valid), 0);
        check("post rst m1_rsp_valid 3", 32'(m1_rsp_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, default 10, SRAM word-address width.
- DATA_WIDTH, default 32, SRAM word width.
- MASK_WIDTH, default 4, byte-lane write-mask width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mN_req_valid  in  1  requester N (N=0,1) has a request.
- mN_req_ready  out  1  request accepted this cycle.
- mN_req_we  in  1  1=write, 0=read.
- mN_req_addr  in  ADDR_WIDTH  word address.
- mN_req_wdata  in  DATA_WIDTH  write data.
- mN_req_mask  in  MASK_WIDTH  byte write enables.
- mN_rsp_valid  out  1  response available to requester N.
- mN_rsp_ready  in  1  requester N takes the response.
- mN_rsp_rdata  out  DATA_WIDTH  read data; 0 for write responses.
- sram_cs  out  1  SRAM chip select.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  ADDR_WIDTH  SRAM address.
- sram_data_in  out  DATA_WIDTH  SRAM write data.
- sram_mask  out  MASK_WIDTH  SRAM byte mask.
- sram_data_out  in  DATA_WIDTH  SRAM registered read data, valid the cycle after a read select, held until the next read select.

Function
REQ-003 The block SHALL share one single-port SRAM between two requesters; every accepted request SHALL produce exactly one response, returned to the requester that issued it.
REQ-004 The state machine SHALL have two states:
- IDLE: no outstanding response.
- RESP: one response outstanding; owner register and type register (read/write) are valid.
REQ-005 The block can accept a request when the state is IDLE, or when the state is RESP and the owner's rsp_valid and rsp_ready are both 1 in the same cycle.
REQ-006 Grant rules:
- If exactly one mN_req_valid is 1, that requester SHALL be granted.
- If both are 1, the requester not granted last SHALL be granted (round-robin).
- last_grant SHALL update only when a request is accepted.
REQ-007 mN_req_ready SHALL equal grant_N AND can-accept, and SHALL depend combinationally only on req_valid, state and rsp_ready.
REQ-008 SRAM drive in an accept cycle:
- sram_cs=1, sram_we=req_we, sram_addr=req_addr.
- sram_data_in=req_wdata.
- sram_mask=req_mask for writes, 0 for reads.
REQ-009 In every non-accept cycle, sram_cs, sram_we and sram_mask SHALL be 0.
REQ-010 On accept, the next state SHALL be RESP with owner=N and type=req_we; otherwise, a response handshake SHALL return the state to IDLE.
REQ-011 In RESP, the owner's rsp_valid SHALL be 1 and the other requester's rsp_valid SHALL be 0. rsp_rdata SHALL be sram_data_out for reads and 0 for writes; a non-owner's rsp_rdata SHALL be 0.
REQ-012 Latency: the response SHALL be valid the cycle after accept, giving a throughput of one request per cycle when rsp_ready is held high.
REQ-013 A held response SHALL stay stable (same valid and data) until its handshake; rsp_ready stall cycles SHALL block all new accepts.
REQ-014 A write with mask=0 SHALL still be accepted and acknowledged; the SRAM is left unchanged.

Reset
REQ-015 While rst_n=0, the block SHALL hold:
- state=IDLE and last_grant=1 (m0 wins the first conflict).
- All req_ready, rsp_valid, sram_cs, sram_we and sram_mask at 0.
- All rsp_rdata at 0.
REQ-016 Reset asserted mid-operation SHALL discard any outstanding response without delivering it. The first cycle after release SHALL behave as IDLE.

Structure
REQ-017 The state encoding (IDLE/RESP) and requester-index constants SHALL be placed in a shared package/header.
REQ-018 Round-robin selection SHALL be a sub-module rr_arb2 (inputs valid[1:0], last_grant; outputs grant[1:0]).
REQ-019 The SRAM SHALL be instantiated outside this block.

Verification
REQ-020 The bench SHALL cover these directed scenarios, using a 1-cycle-latency SRAM model:
- Reset: after rst_n=0 then release, with no requests -> all outputs 0 and sram_cs=0 each cycle.
- Single write then read: m0 writes addr 0x10, data 0xDEADBEEF, mask 0xF; then m0 reads addr 0x10 -> write response rdata 0, read response rdata 0xDEADBEEF, one cycle after each accept.
- Byte mask: addr 0x20 holds 0x11223344; m1 writes 0xAABBCCDD with mask 0x2 -> a later read returns 0x1122CC44.
- Conflict: both requesters hold valid for 4 cycles with rsp_ready=1 -> grants are m0,m1,m0,m1 and each response goes only to its issuer.
- Backpressure: m0 read response is held with rsp_ready=0 for 3 cycles while m1 is valid -> m1_req_ready=0 and rsp_rdata stays stable. When rsp_ready=1, m1 is accepted in that same cycle.
- Mid-operation reset: rst_n=0 while in RESP -> rsp_valid drops asynchronously to 0, and no response appears after release.
